// File: rtl/secuenciador_melodia_if.sv
// Key-bus interface between the melody sequencer and whatever drives it.
//   master : supplies the raw keys (teclas_in), play/stop requests and the
//            loop level; observes the key bus and the status outputs.
//   slave  : the sequencer itself; drives teclas_out, ocupado, fin, indice.
interface secuenciador_melodia_if;
  logic [6:0] teclas_in;
  logic       play;
  logic       stop;
  logic       loop;
  logic [6:0] teclas_out;
  logic       ocupado;
  logic       fin;
  logic [3:0] indice;

  modport master (
    output teclas_in, play, stop, loop,
    input  teclas_out, ocupado, fin, indice
  );

  modport slave (
    input  teclas_in, play, stop, loop,
    output teclas_out, ocupado, fin, indice
  );
endinterface

// File: rtl/secuenciador_melodia.sv
// Melody sequencer / key arbiter in front of the tone generator.
// When idle it forwards the highest pressed manual key as one-hot; on a play
// request it steps through a 16-entry song ROM ({nota[2:0], dur[3:0]}),
// holding each note for dur*TICK_DIV cycles followed by GAP_TICKS*TICK_DIV
// silent cycles.
//   clk, reset      : system clock, synchronous active-high reset
//   sec.teclas_in   : raw manual keys (bit6 = do ... bit0 = si)
//   sec.play/stop   : start / abort requests, sampled every cycle
//   sec.loop        : level, restart the song after its end
//   sec.teclas_out  : registered one-hot (or zero) key bus
//   sec.ocupado     : high while loading/playing/gapping
//   sec.fin         : one-cycle pulse when a non-looping song completes
//   sec.indice      : current ROM step
module secuenciador_melodia #(
  parameter int unsigned TICK_DIV  = 2_500_000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  secuenciador_melodia_if.slave   sec
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_t;

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned NW = (GAP_TICKS > 15) ? $clog2(GAP_TICKS + 1) : 4;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [NW-1:0] GAP_LAST  = NW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  // Song ROM: notes 1..7 for four ticks each, a two-tick rest, then end markers.
  function automatic logic [6:0] rom_entry(input logic [3:0] addr);
    logic [6:0] e;
    e = '0;
    if (addr <= 4'd6) begin
      e = {3'(addr) + 3'd1, 4'd4};
    end else if (addr == 4'd7) begin
      e = {3'd0, 4'd2};
    end
    return e;
  endfunction

  // Note n (1..7) drives bit 7-n; note 0 is a rest.
  function automatic logic [6:0] nota_onehot(input logic [2:0] n);
    logic [6:0] r;
    r = '0;
    if (n != 3'd0) begin
      r[3'd7 - n] = 1'b1;
    end
    return r;
  endfunction

  // Highest pressed key wins: ascending scan lets later (higher) bits override.
  function automatic logic [6:0] prio_onehot(input logic [6:0] k);
    logic [6:0] r;
    r = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (k[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      indice_q, indice_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [NW-1:0]   n_q, n_d;
  logic [2:0]      nota_q, nota_d;
  logic [3:0]      dur_q, dur_d;
  logic [6:0]      teclas_q, teclas_d;

  logic [6:0]      entry;
  logic            tick_end;
  logic            do_adv;
  logic            phase_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      indice_q <= '0;
      tick_q   <= '0;
      n_q      <= '0;
      nota_q   <= '0;
      dur_q    <= '0;
      teclas_q <= '0;
    end else begin
      state_q  <= state_d;
      indice_q <= indice_d;
      tick_q   <= tick_d;
      n_q      <= n_d;
      nota_q   <= nota_d;
      dur_q    <= dur_d;
      teclas_q <= teclas_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    indice_d  = indice_q;
    tick_d    = tick_q;
    n_d       = n_q;
    nota_d    = nota_q;
    dur_d     = dur_q;
    teclas_d  = teclas_q;
    do_adv    = 1'b0;
    phase_end = 1'b0;
    entry     = rom_entry(indice_q);
    tick_end  = (tick_q == TICK_LAST);

    case (state_q)
      IDLE: begin
        teclas_d = prio_onehot(sec.teclas_in);
        tick_d   = '0;
        n_d      = '0;
        if (sec.play && !sec.stop) begin
          state_d  = LOAD;
          indice_d = '0;
          teclas_d = '0;
        end
      end

      LOAD: begin
        teclas_d = '0;
        tick_d   = '0;
        n_d      = '0;
        if (entry[3:0] != 4'd0) begin
          state_d  = PLAY;
          nota_d   = entry[6:4];
          dur_d    = entry[3:0];
          teclas_d = nota_onehot(entry[6:4]);
        end else if (sec.loop && (indice_q != 4'd0)) begin
          indice_d = '0;
        end else begin
          state_d = DONE;
        end
      end

      PLAY, GAP: begin
        // Both phases count whole ticks; only the tick limit differs.
        if (tick_end) begin
          tick_d = '0;
          if (state_q == PLAY) begin
            phase_end = (n_q == NW'(dur_q - 4'd1));
          end else begin
            phase_end = (n_q == GAP_LAST);
          end
          if (!phase_end) begin
            n_d = n_q + NW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
        if (phase_end) begin
          n_d = '0;
          if ((state_q == PLAY) && (GAP_TICKS > 0)) begin
            state_d  = GAP;
            teclas_d = '0;
          end else begin
            do_adv = 1'b1;
          end
        end
      end

      DONE: begin
        teclas_d = '0;
        state_d  = IDLE;
      end

      default: begin
        state_d  = IDLE;
        teclas_d = '0;
      end
    endcase

    if (do_adv) begin
      teclas_d = '0;
      tick_d   = '0;
      n_d      = '0;
      if (indice_q < 4'd15) begin
        indice_d = indice_q + 4'd1;
        state_d  = LOAD;
      end else if (sec.loop) begin
        indice_d = '0;
        state_d  = LOAD;
      end else begin
        state_d = DONE;
      end
    end

    if (sec.stop && (state_q != IDLE)) begin
      state_d  = IDLE;
      teclas_d = '0;
      tick_d   = '0;
      n_d      = '0;
    end
  end

  assign sec.teclas_out = teclas_q;
  assign sec.indice     = indice_q;
  assign sec.ocupado    = (state_q == LOAD) || (state_q == PLAY) || (state_q == GAP);
  assign sec.fin        = (state_q == DONE);

endmodule

// File: tb/tb_secuenciador_melodia.sv
module tb_secuenciador_melodia;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   t;

  secuenciador_melodia_if sif();

  secuenciador_melodia #(
    .TICK_DIV  (4),
    .GAP_TICKS (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sec   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    t = t + 1;
  endtask

  // Pulse play; afterwards t = 0 means "just after edge k".
  task automatic start_song();
    sif.play = 1'b1;
    tick();
    sif.play = 1'b0;
    t = 0;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  // Expected key bus for the default song, t cycles after the play edge.
  function automatic logic [6:0] exp_song(input int tt);
    logic [6:0] r;
    r = '0;
    for (int s = 0; s < 8; s++) begin
      int         start;
      int         d;
      logic [6:0] note;
      start = 21 * s;
      d     = (s < 7) ? 4 : 2;
      note  = (s < 7) ? (7'b1000000 >> s) : 7'b0000000;
      if (tt > start && tt <= start + 4 * d) r = note;
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    sif.play = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sif.play = 1'b0;
    checks++;
    if (sif.teclas_out !== 7'b0) begin
      errors++; $display("FAIL reset_teclas got %b want %b", sif.teclas_out, 7'b0);
    end
    checks++;
    if (sif.ocupado !== 1'b0) begin
      errors++; $display("FAIL reset_ocupado got %b want 0", sif.ocupado);
    end
    checks++;
    if (sif.fin !== 1'b0) begin
      errors++; $display("FAIL reset_fin got %b want 0", sif.fin);
    end
    checks++;
    if (sif.indice !== 4'd0) begin
      errors++; $display("FAIL reset_indice got %0d want 0", sif.indice);
    end
  endtask

  task automatic test_manual();
    logic [6:0] vin [4];
    logic [6:0] vexp [4];
    vin[0] = 7'b0011000; vexp[0] = 7'b0010000;
    vin[1] = 7'b0110000; vexp[1] = 7'b0100000;
    vin[2] = 7'b0000000; vexp[2] = 7'b0000000;
    vin[3] = 7'b1111111; vexp[3] = 7'b1000000;
    for (int i = 0; i < 4; i++) begin
      sif.teclas_in = vin[i];
      tick();
      checks++;
      if (sif.teclas_out !== vexp[i]) begin
        errors++; $display("FAIL manual_%0d got %b want %b", i, sif.teclas_out, vexp[i]);
      end
      checks++;
      if (sif.ocupado !== 1'b0) begin
        errors++; $display("FAIL manual_ocupado_%0d got %b want 0", i, sif.ocupado);
      end
    end
    sif.teclas_in = 7'b0;
    tick();
  endtask

  // Whole song without loop; manual key held throughout must not leak through.
  task automatic test_full_song();
    int fin_count;
    int fin_at;
    logic exp_ocu;
    fin_count = 0;
    fin_at = -1;
    sif.teclas_in = 7'b0000001;
    start_song();
    checks++;
    if (sif.ocupado !== 1'b1 || sif.teclas_out !== 7'b0 || sif.indice !== 4'd0) begin
      errors++;
      $display("FAIL song_start got ocu=%b teclas=%b idx=%0d want ocu=1 teclas=0 idx=0",
               sif.ocupado, sif.teclas_out, sif.indice);
    end
    while (t < 162) begin
      tick();
      checks++;
      if (sif.teclas_out !== exp_song(t)) begin
        errors++; $display("FAIL song_teclas t=%0d got %b want %b", t, sif.teclas_out, exp_song(t));
      end
      exp_ocu = (t <= 160);
      checks++;
      if (sif.ocupado !== exp_ocu) begin
        errors++; $display("FAIL song_ocupado t=%0d got %b want %b", t, sif.ocupado, exp_ocu);
      end
      if (sif.fin === 1'b1) begin
        fin_count++;
        fin_at = t;
      end
      if (t == 21) begin
        checks++;
        if (sif.indice !== 4'd1) begin
          errors++; $display("FAIL song_indice1 got %0d want 1", sif.indice);
        end
      end
    end
    checks++;
    if (fin_count != 1 || fin_at != 161) begin
      errors++; $display("FAIL song_fin got count=%0d at=%0d want count=1 at=161", fin_count, fin_at);
    end
    tick();
    checks++;
    if (sif.teclas_out !== 7'b0000001) begin
      errors++; $display("FAIL song_manual_after got %b want %b", sif.teclas_out, 7'b0000001);
    end
    sif.teclas_in = 7'b0;
    tick();
  endtask

  task automatic test_loop();
    int fin_count;
    fin_count = 0;
    sif.loop = 1'b1;
    start_song();
    while (t < 170) begin
      tick();
      if (sif.fin === 1'b1) fin_count++;
      if (t == 160) begin
        checks++;
        if (sif.indice !== 4'd8) begin
          errors++; $display("FAIL loop_idx_end got %0d want 8", sif.indice);
        end
      end
      if (t == 161) begin
        checks++;
        if (sif.indice !== 4'd0 || sif.teclas_out !== 7'b0) begin
          errors++; $display("FAIL loop_restart got idx=%0d teclas=%b want idx=0 teclas=0",
                             sif.indice, sif.teclas_out);
        end
      end
      if (t == 162) begin
        checks++;
        if (sif.teclas_out !== 7'b1000000 || sif.ocupado !== 1'b1) begin
          errors++; $display("FAIL loop_replay got teclas=%b ocu=%b want 1000000 1",
                             sif.teclas_out, sif.ocupado);
        end
      end
    end
    checks++;
    if (fin_count != 0) begin
      errors++; $display("FAIL loop_fin got %0d pulses want 0", fin_count);
    end
    sif.stop = 1'b1;
    sif.loop = 1'b0;
    tick();
    sif.stop = 1'b0;
    checks++;
    if (sif.ocupado !== 1'b0 || sif.teclas_out !== 7'b0) begin
      errors++; $display("FAIL loop_stop got ocu=%b teclas=%b want 0 0", sif.ocupado, sif.teclas_out);
    end
  endtask

  task automatic test_stop();
    start_song();
    run_to(70);
    checks++;
    if (sif.teclas_out !== 7'b0001000 || sif.indice !== 4'd3) begin
      errors++; $display("FAIL stop_pre got teclas=%b idx=%0d want 0001000 3", sif.teclas_out, sif.indice);
    end
    sif.stop = 1'b1;
    tick();
    sif.stop = 1'b0;
    checks++;
    if (sif.teclas_out !== 7'b0 || sif.ocupado !== 1'b0 || sif.fin !== 1'b0) begin
      errors++; $display("FAIL stop_post got teclas=%b ocu=%b fin=%b want 0 0 0",
                         sif.teclas_out, sif.ocupado, sif.fin);
    end
    sif.teclas_in = 7'b0000100;
    tick();
    checks++;
    if (sif.teclas_out !== 7'b0000100 || sif.fin !== 1'b0) begin
      errors++; $display("FAIL stop_manual got teclas=%b fin=%b want 0000100 0", sif.teclas_out, sif.fin);
    end
    sif.teclas_in = 7'b0;
    tick();
  endtask

  task automatic test_play_stop_same();
    sif.teclas_in = 7'b0100000;
    sif.play = 1'b1;
    sif.stop = 1'b1;
    tick();
    tick();
    sif.play = 1'b0;
    sif.stop = 1'b0;
    checks++;
    if (sif.ocupado !== 1'b0 || sif.teclas_out !== 7'b0100000) begin
      errors++; $display("FAIL play_stop got ocu=%b teclas=%b want 0 0100000", sif.ocupado, sif.teclas_out);
    end
    sif.teclas_in = 7'b0;
    tick();
  endtask

  task automatic test_play_during_play();
    start_song();
    run_to(30);
    sif.play = 1'b1;
    tick();
    sif.play = 1'b0;
    checks++;
    if (sif.indice !== 4'd1 || sif.teclas_out !== 7'b0100000) begin
      errors++; $display("FAIL play_ignored got idx=%0d teclas=%b want 1 0100000", sif.indice, sif.teclas_out);
    end
  endtask

  // Continues the song started above into step 1's gap, then resets.
  task automatic test_reset_gap();
    run_to(39);
    checks++;
    if (sif.teclas_out !== 7'b0 || sif.ocupado !== 1'b1 || sif.indice !== 4'd1) begin
      errors++; $display("FAIL gap_pre got teclas=%b ocu=%b idx=%0d want 0 1 1",
                         sif.teclas_out, sif.ocupado, sif.indice);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (sif.teclas_out !== 7'b0 || sif.ocupado !== 1'b0 || sif.fin !== 1'b0 || sif.indice !== 4'd0) begin
      errors++; $display("FAIL gap_reset got teclas=%b ocu=%b fin=%b idx=%0d want all 0",
                         sif.teclas_out, sif.ocupado, sif.fin, sif.indice);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    t = 0;
    reset = 1'b0;
    sif.teclas_in = 7'b0;
    sif.play = 1'b0;
    sif.stop = 1'b0;
    sif.loop = 1'b0;
    test_reset();
    test_manual();
    test_full_song();
    test_loop();
    test_stop();
    test_play_stop_same();
    test_play_during_play();
    test_reset_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
